// File: rtl/binning_pkg.sv
// binning_pkg: mode encodings, fixed latency and width helper
// shared by the N x N binning block and its column buffer.
package binning_pkg;

  typedef enum logic [1:0] {
    MODE_BYPASS = 2'd0,
    MODE_2X2    = 2'd1,
    MODE_4X4    = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_e;

  localparam int LAT = 4;

  function automatic int acc_width(input int pw);
    return pw + 2;
  endfunction

endpackage

// File: rtl/binning_colbuf.sv
// binning_colbuf: simple dual-port RAM holding partial column sums,
// one write port and one registered read port.
module binning_colbuf #(
  parameter  int DEPTH = 512,
  parameter  int WIDTH = 12,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/binning_nxn.sv
// binning_nxn: runtime-selectable bypass / 2x2 / 4x4 pixel binning
// on packed multi-channel video with a fixed 4-clock latency.
module binning_nxn
  import binning_pkg::*;
#(
  parameter int PIXEL_WIDTH   = 8,
  parameter int CHANNELS      = 1,
  parameter int LINE_SIZE_MAX = 1024,
  parameter int ROUND         = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [1:0]                      mode_i,
  input  logic [CHANNELS*PIXEL_WIDTH-1:0] di_i,
  input  logic                            de_i,
  input  logic                            hs_i,
  input  logic                            vs_i,
  output logic [CHANNELS*PIXEL_WIDTH-1:0] do_o,
  output logic                            de_o,
  output logic                            hs_o,
  output logic                            vs_o,
  output logic                            ovf_o
);

  localparam int PW    = PIXEL_WIDTH;
  localparam int HW    = acc_width(PW);
  localparam int TW    = PW + 4;
  localparam int DW    = CHANNELS * PW;
  localparam int HT    = CHANNELS * HW;
  localparam int EW    = CHANNELS * TW;
  localparam int DEPTH = LINE_SIZE_MAX / 2;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = $clog2(LINE_SIZE_MAX + 1);

  logic              vs_q, hs_q, armed, line_de;
  logic [1:0]        k, k_new, nm1, rg, h_rg;
  logic [CW-1:0]     col;
  logic [HT-1:0]     hacc, hnext, h_sum;
  logic              h_v, t_v, r_v;
  logic [AW-1:0]     h_addr, rd_addr;
  logic [EW-1:0]     t_sum, vsum, hext, wdata, rdata;
  logic [TW-1:0]     rnd;
  logic [DW-1:0]     r_d, dnext;
  logic [2:0]        b_v;
  logic [2:0][DW-1:0] b_d;
  logic [LAT-1:0]    hs_d, vs_d;
  logic              vs_rise, hs_rise, pix, ok;
  logic              blk_end, we;

  always_comb begin
    k_new = 2'd0;
    unique case (mode_e'(mode_i))
      MODE_2X2: k_new = 2'd1;
      MODE_4X4: k_new = 2'd2;
      default:  k_new = 2'd0;
    endcase
  end

  assign vs_rise = vs_i & ~vs_q;
  assign hs_rise = hs_i & ~hs_q;
  assign pix     = armed & de_i & ~hs_i;
  assign ok      = pix & (col != CW'(LINE_SIZE_MAX));
  assign nm1     = (k == 2'd2) ? 2'd3 :
                   (k == 2'd1) ? 2'd1 : 2'd0;
  assign blk_end = ok && (k != 2'd0) &&
                   ((col[1:0] & nm1) == nm1);
  assign rd_addr = AW'(col >> k);
  assign rnd     = (ROUND == 0)  ? '0 :
                   (k == 2'd2)   ? TW'(8) : TW'(2);
  assign we      = h_v && (h_rg != nm1);
  assign wdata   = (h_rg == 2'd0) ? hext : vsum;

  always_comb begin
    hnext = '0;
    hext  = '0;
    vsum  = '0;
    dnext = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      hnext[c*HW +: HW] = hacc[c*HW +: HW]
                        + HW'(di_i[c*PW +: PW]);
      hext[c*TW +: TW]  = TW'(h_sum[c*HW +: HW]);
      vsum[c*TW +: TW]  = rdata[c*TW +: TW]
                        + hext[c*TW +: TW];
      dnext[c*PW +: PW] = PW'((t_sum[c*TW +: TW] + rnd)
                              >> {k, 1'b0});
    end
  end

  binning_colbuf #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_colbuf (
    .clk   (clk),
    .we    (we),
    .waddr (h_addr),
    .wdata (wdata),
    .raddr (rd_addr),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      // vs_q/hs_q start high so a reset mid-frame never looks like a rise
      vs_q    <= 1'b1;
      hs_q    <= 1'b1;
      armed   <= 1'b0;
      k       <= 2'd0;
      ovf_o   <= 1'b0;
      col     <= '0;
      rg      <= 2'd0;
      line_de <= 1'b0;
      hacc    <= '0;
      h_v     <= 1'b0;
      h_rg    <= 2'd0;
      h_addr  <= '0;
      h_sum   <= '0;
      t_v     <= 1'b0;
      t_sum   <= '0;
      r_v     <= 1'b0;
      r_d     <= '0;
      b_v     <= '0;
      b_d     <= '0;
      hs_d    <= '1;
      vs_d    <= '0;
      de_o    <= 1'b0;
      do_o    <= '0;
    end else begin
      vs_q <= vs_i;
      hs_q <= hs_i;
      hs_d <= {hs_d[LAT-2:0], hs_i};
      vs_d <= {vs_d[LAT-2:0], vs_i};

      if (vs_rise) begin
        armed <= 1'b1;
        k     <= k_new;
        ovf_o <= 1'b0;
      end
      if (pix && !ok) ovf_o <= 1'b1;

      if (hs_i) col <= '0;
      else if (ok) col <= col + CW'(1);

      if (hs_i) hacc <= '0;
      else if (ok) hacc <= blk_end ? '0 : hnext;

      if (ok) line_de <= 1'b1;
      if (!vs_i) begin
        rg      <= 2'd0;
        line_de <= 1'b0;
      end else if (hs_rise && line_de) begin
        rg      <= (rg == nm1) ? 2'd0 : rg + 2'd1;
        line_de <= 1'b0;
      end

      h_v <= blk_end;
      if (blk_end) begin
        h_sum  <= hnext;
        h_rg   <= rg;
        h_addr <= rd_addr;
      end

      t_v <= h_v && (h_rg == nm1);
      if (h_v && (h_rg == nm1)) t_sum <= vsum;

      r_v <= t_v;
      if (t_v) r_d <= dnext;

      b_v <= {b_v[1:0], ok};
      b_d <= {b_d[1:0], di_i};

      if (k == 2'd0) begin
        de_o <= b_v[2];
        do_o <= b_d[2];
      end else begin
        de_o <= r_v;
        if (r_v) do_o <= r_d;
      end
    end
  end

  assign hs_o = hs_d[LAT-1];
  assign vs_o = vs_d[LAT-1];

endmodule
